// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and types for the 640x480@60 Hz raster generator.
//   - Default porch/sync/active sizes for both axes and the derived totals.
//   - Coordinate widths expected by the downstream colour generator.
//   - vga_out_t: the registered output bundle driven by vga_scan_timer.
//   - cnt_width(): counter width helper that never returns zero.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned DEF_CLK_DIV  = 2;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  typedef struct packed {
    logic           blank_n;
    logic           hsync_n;
    logic           vsync_n;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_start;
    logic           frame_start;
  } vga_out_t;

  // Idle picture: blanked, both syncs inactive, no markers.
  localparam vga_out_t VGA_OUT_RESET = '{
    blank_n:     1'b0,
    hsync_n:     1'b1,
    vsync_n:     1'b1,
    x:           '0,
    y:           '0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  // Width needed to hold 0..n-1; a modulus of 1 still gets a 1-bit register.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Generic wrap-around raster counter for one axis (horizontal or vertical).
// The count runs 0..TOTAL-1 advancing only when i_en is high, then wraps to 0.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_en         : advance strobe
//   o_count      : current position on the axis
//   o_active     : position lies in the visible region
//   o_sync       : position lies inside the sync pulse
//   o_wrap       : position is the last one; the next advance returns to 0
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter  int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter  int unsigned FP     = DEF_H_FP,
  parameter  int unsigned SYNC   = DEF_H_SYNC,
  parameter  int unsigned BP     = DEF_H_BP,
  localparam int unsigned TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int unsigned W      = cnt_width(TOTAL)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_active,
  output logic         o_sync,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST);

  // Position register: steps once per enable and folds back to 0 after the
  // final back-porch position so the sequence is exactly TOTAL long.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_at_last ? '0 : r_count + W'(1);
    end
  end

  // Region decodes are purely combinational on the current position; the
  // parent registers them so their glitches never reach the pins.
  assign o_count  = r_count;
  assign o_active = (r_count < ACT_END);
  assign o_sync   = (r_count >= SYNC_FIRST) && (r_count <= SYNC_LAST);
  assign o_wrap   = w_at_last;

endmodule

// File: rtl/vga_scan_timer.sv
// -----------------------------------------------------------------------------
// vga_scan_timer
// Raster timing generator for the VGA output path (640x480@60 Hz by default).
// A clock divider produces a pixel strobe; horizontal and vertical counters
// step on it, and sync/blank/coordinates/markers are registered on the same
// strobe, one pixel behind the counters.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   pix_en       : one-clk strobe every CLK_DIV clocks (constant 1 if CLK_DIV=1)
//   x, y         : pixel coordinates, forced to 0 while blanked
//   hsync_n      : horizontal sync, active low
//   vsync_n      : vertical sync, active low
//   blank_n      : 1 inside the visible region
//   line_start   : one-pixel pulse at x=0 of each visible line
//   frame_start  : one-pixel pulse at x=0, y=0
// -----------------------------------------------------------------------------
module vga_scan_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic           pix_en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           blank_n,
  output logic           line_start,
  output logic           frame_start
);

  localparam int unsigned DIV_W = cnt_width(CLK_DIV);
  localparam int unsigned HW    = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VW    = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_pix_en;

  logic [HW-1:0]    w_h_count;
  logic             w_h_active;
  logic             w_h_sync;
  logic             w_h_wrap;

  logic [VW-1:0]    w_v_count;
  logic             w_v_active;
  logic             w_v_sync;
  logic             w_v_wrap;

  logic             w_visible;
  vga_out_t         w_out_next;
  vga_out_t         r_out;

  // Pixel divider: counts system clocks within a pixel. With CLK_DIV=1 the
  // register sits at 0, which equals DIV_LAST, so the strobe stays high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

  assign w_pix_en = (r_div_cnt == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (w_pix_en),
    .o_count  (w_h_count),
    .o_active (w_h_active),
    .o_sync   (w_h_sync),
    .o_wrap   (w_h_wrap)
  );

  // The vertical axis only moves when the horizontal one is about to fold
  // back to 0, i.e. once per full line.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (w_pix_en & w_h_wrap),
    .o_count  (w_v_count),
    .o_active (w_v_active),
    .o_sync   (w_v_sync),
    .o_wrap   (w_v_wrap)
  );

  assign w_visible = w_h_active & w_v_active;

  // Next output bundle. Coordinates are zeroed outside the visible area so
  // the narrow y bus never shows an aliased copy of the blanking lines.
  always_comb begin
    w_out_next             = VGA_OUT_RESET;
    w_out_next.blank_n     = w_visible;
    w_out_next.hsync_n     = ~w_h_sync;
    w_out_next.vsync_n     = ~w_v_sync;
    if (w_visible) begin
      w_out_next.x = X_W'(w_h_count);
      w_out_next.y = Y_W'(w_v_count);
    end
    w_out_next.line_start  = (w_h_count == '0) & w_v_active;
    w_out_next.frame_start = (w_h_count == '0) & (w_v_count == '0) & ~w_v_wrap;
  end

  // Output register, loaded once per pixel so every pin holds for a full
  // CLK_DIV clocks and changes together with the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= VGA_OUT_RESET;
    end else if (w_pix_en) begin
      r_out <= w_out_next;
    end
  end

  assign pix_en      = w_pix_en;
  assign x           = r_out.x;
  assign y           = r_out.y;
  assign hsync_n     = r_out.hsync_n;
  assign vsync_n     = r_out.vsync_n;
  assign blank_n     = r_out.blank_n;
  assign line_start  = r_out.line_start;
  assign frame_start = r_out.frame_start;

endmodule
